// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issuer: opcode map, result error codes
// and the issuer state encoding.
package fpu_pkg;

    localparam logic [3:0] OP_FADD  = 4'd1;
    localparam logic [3:0] OP_FSUB  = 4'd2;
    localparam logic [3:0] OP_FMUL  = 4'd3;
    localparam logic [3:0] OP_FDIV  = 4'd4;
    localparam logic [3:0] OP_FEQ   = 4'd5;
    localparam logic [3:0] OP_FLT   = 4'd6;
    localparam logic [3:0] OP_FLE   = 4'd7;
    localparam logic [3:0] OP_FSQRT = 4'd8;
    localparam logic [3:0] OP_FNEG  = 4'd9;
    localparam logic [3:0] OP_ITOF  = 4'd10;
    localparam logic [3:0] OP_FTOI  = 4'd11;

    localparam logic [2:0] ERR_OK  = 3'd0;
    localparam logic [2:0] ERR_FPU = 3'd1;
    localparam logic [2:0] ERR_ILL = 3'd2;
    localparam logic [2:0] ERR_TO  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER,
        ST_DELIVER_TO,
        ST_DRAIN
    } state_t;

    // Opcodes outside the contiguous FADD..FTOI range never reach the FPU.
    function automatic logic is_legal_op(input logic [3:0] ope);
        return (ope >= OP_FADD) && (ope <= OP_FTOI);
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the FPU issuer; head entry is visible combinationally
// so the issuer can decode the opcode in the same cycle it pops.
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_issuer.sv
// Requester-side master for the FPU: queues commands, issues one op at a
// time, tags and returns each result, and recovers from a hung FPU.
module fpu_issuer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [3:0]       cmd_ope,
    input  logic [31:0]      cmd_in1,
    input  logic [31:0]      cmd_in2,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             f_in_vld,
    input  logic             f_in_rdy,
    output logic [3:0]       f_ope_data,
    output logic [31:0]      f_in1_data,
    output logic [31:0]      f_in2_data,
    input  logic             f_out_vld,
    output logic             f_out_rdy,
    input  logic [31:0]      f_out_data,
    input  logic [2:0]       f_err,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [2:0]       res_err
);

    localparam int             FW      = 4 + 32 + 32 + TAG_W;
    localparam int             CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [FW-1:0]    w_head;
    logic [3:0]       w_ope;
    logic [31:0]      w_in1;
    logic [31:0]      w_in2;
    logic [TAG_W-1:0] w_tag;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_f_in_vld;
    logic [3:0]       r_f_ope;
    logic [31:0]      r_f_in1;
    logic [31:0]      r_f_in2;
    logic             r_f_out_rdy;
    logic             r_res_vld;
    logic [31:0]      r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic [2:0]       r_res_err;

    assign cmd_rdy = !rst && !w_full;
    assign w_push  = cmd_vld && cmd_rdy;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign {w_ope, w_in1, w_in2, w_tag} = w_head;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({cmd_ope, cmd_in1, cmd_in2, cmd_tag}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_f_in_vld  <= 1'b0;
            r_f_ope     <= '0;
            r_f_in1     <= '0;
            r_f_in2     <= '0;
            r_f_out_rdy <= 1'b0;
            r_res_vld   <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        // Tag is latched at pop so every exit path can report it.
                        r_res_tag <= w_tag;
                        if (is_legal_op(w_ope)) begin
                            r_f_ope    <= w_ope;
                            r_f_in1    <= w_in1;
                            r_f_in2    <= w_in2;
                            r_f_in_vld <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_res_data <= '0;
                            r_res_err  <= ERR_ILL;
                            r_res_vld  <= 1'b1;
                            r_state    <= ST_DELIVER;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (f_in_rdy) begin
                        r_f_in_vld  <= 1'b0;
                        r_f_out_rdy <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result landing on the final count still wins over the timeout.
                    if (f_out_vld) begin
                        r_res_data  <= f_out_data;
                        r_res_err   <= f_err[0] ? ERR_FPU : ERR_OK;
                        r_res_vld   <= 1'b1;
                        r_f_out_rdy <= 1'b0;
                        r_state     <= ST_DELIVER;
                    end else if (r_cnt == TO_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= ERR_TO;
                        r_res_vld   <= 1'b1;
                        r_f_out_rdy <= 1'b0;
                        r_state     <= ST_DELIVER_TO;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DELIVER: begin
                    if (res_rdy) begin
                        r_res_vld <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DELIVER_TO: begin
                    if (res_rdy) begin
                        r_res_vld   <= 1'b0;
                        r_f_out_rdy <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The late result of the timed-out op is swallowed here.
                    if (f_out_vld) begin
                        r_f_out_rdy <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_in_vld   = r_f_in_vld;
    assign f_ope_data = r_f_ope;
    assign f_in1_data = r_f_in1;
    assign f_in2_data = r_f_in2;
    assign f_out_rdy  = r_f_out_rdy;
    assign res_vld    = r_res_vld;
    assign res_data   = r_res_data;
    assign res_tag    = r_res_tag;
    assign res_err    = r_res_err;

endmodule
